// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - tx_state_e : framing FSM states
//   - log2       : bit count of a value (number of bits needed to hold it)
//   - acc_width  : baud accumulator width from clock and baud rate
//   - acc_inc    : baud accumulator increment from clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Counts bits up to the highest set bit, so log2(16) = 5.
  function automatic int unsigned log2(input longint unsigned v);
    int unsigned n;
    n = 0;
    while ((v >> n) != 64'd0) n++;
    return n;
  endfunction

  function automatic int unsigned acc_width(input int unsigned clk_hz, input int unsigned baud);
    return log2(64'(clk_hz / baud)) + 8;
  endfunction

  // Rounded Baud * 2^W / ClkFrequency, computed with both sides pre-scaled by 16.
  function automatic int unsigned acc_inc(input int unsigned clk_hz, input int unsigned baud);
    int unsigned     w;
    longint unsigned num;
    w   = acc_width(clk_hz, baud);
    num = (64'(baud) << (w - 4)) + 64'(clk_hz >> 5);
    return 32'(num / 64'(clk_hz >> 4));
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side bus of the UART transmit scheduler.
//   req/data   : level requests and per-requester bytes (byte i at [8i+7:8i])
//   ack        : one-hot capture pulse
//   grant_id   : requester being served, valid while busy
//   busy, txd  : frame in progress, serial line (idle high)
// master: requester side; slave: scheduler side.
interface uart_tx_sched_if #(
  parameter int unsigned NumReq = 4
);
  localparam int unsigned IdW = $clog2(NumReq);

  logic [NumReq-1:0]   req;
  logic [8*NumReq-1:0] data;
  logic [NumReq-1:0]   ack;
  logic [IdW-1:0]      grant_id;
  logic                busy;
  logic                txd;

  modport master (output req, output data, input ack, input grant_id, input busy, input txd);
  modport slave  (input req, input data, output ack, output grant_id, output busy, output txd);

endinterface

// File: rtl/uart_baud_acc.sv
// Enable-gated fractional baud tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable_i   : count while high; while low the accumulator reloads to Inc
//   tick_o     : carry out of the W-bit fraction, one cycle per bit period
module uart_baud_acc #(
  parameter int unsigned W   = 13,
  parameter int unsigned Inc = 512
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [W:0] IncV = (W + 1)'(Inc);

  logic [W:0] acc_q, acc_d;

  // Reloading while disabled keeps every frame phase-aligned to its grant.
  always_comb begin
    acc_d = IncV;
    if (enable_i) acc_d = {1'b0, acc_q[W-1:0]} + IncV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= IncV;
    else        acc_q <= acc_d;
  end

  assign tick_o = acc_q[W];

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler and framing controller sharing one UART TX line.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_sched_if.slave (req, data, ack, grant_id, busy, txd)
// Frame: start, 8 data bits LSB first, [even parity], stop.
// Optional: define UART_TX_SCHED_PARITY_EN to insert the parity bit.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned NumReq       = 4
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned IdW    = $clog2(NumReq);
  localparam int unsigned AccW   = acc_width(ClkFrequency, Baud);
  localparam int unsigned AccInc = acc_inc(ClkFrequency, Baud);
  localparam logic [IdW-1:0] LastId = IdW'(NumReq - 1);

  tx_state_e         state_q;
  logic [IdW-1:0]    rr_ptr_q, grant_id_q;
  logic [NumReq-1:0] ack_q;
  logic              busy_q, txd_q;
  logic [7:0]        shreg_q;
  logic [2:0]        bitcnt_q;
`ifdef UART_TX_SCHED_PARITY_EN
  logic              parity_q;
`endif

  logic              gnt_valid;
  logic [IdW-1:0]    gnt_idx, cand, rr_next;
  logic [7:0]        gnt_byte;
  logic              tick;
  logic              baud_en;

  assign baud_en = (state_q != StIdle);

  uart_baud_acc #(
    .W   (AccW),
    .Inc (AccInc)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (baud_en),
    .tick_o   (tick)
  );

  // First set request at or after rr_ptr, wrapping modulo NumReq.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdW'((32'(rr_ptr_q) + i) % NumReq);
      if (!gnt_valid && bus.req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_byte = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (IdW'(i) == gnt_idx) gnt_byte = bus.data[8*i +: 8];
    end
    rr_next = (gnt_idx == LastId) ? '0 : gnt_idx + IdW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            ack_q      <= NumReq'(1) << gnt_idx;
            shreg_q    <= gnt_byte;
            grant_id_q <= gnt_idx;
            rr_ptr_q   <= rr_next;
            busy_q     <= 1'b1;
            txd_q      <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
            parity_q   <= ^gnt_byte;
`endif
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            bitcnt_q <= '0;
            txd_q    <= shreg_q[0];
            state_q  <= StData;
          end
        end
        StData: begin
          if (tick) begin
            shreg_q  <= shreg_q >> 1;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
              txd_q   <= parity_q;
              state_q <= StParity;
`else
              txd_q   <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              txd_q <= shreg_q[1];
            end
          end
        end
`ifdef UART_TX_SCHED_PARITY_EN
        StParity: begin
          if (tick) begin
            txd_q   <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (tick) begin
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.txd      = txd_q;

endmodule
